cla_add_arbiter: RTL and testbench

//  Shares one external cla_32bit adder among NUM_REQ requesters issuing ADD/SUB ops.
//  A round-robin arbiter grants one request at a time.
//  A 3-state FSM sequences each op: accept, drive the adder, return the response.

---
 rtl/cla_add_arbiter.sv | 145 ++++++++++++++
 tb/tb_cla_add_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_add_arbiter.sv
// Round-robin front end that shares one external cla_32bit adder among NUM_REQ ADD/SUB clients.
// Define ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module cla_add_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 32,
   parameter int IDW     = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ-1:0]       req_sub,
   input  logic [NUM_REQ*WIDTH-1:0] req_a,
   input  logic [NUM_REQ*WIDTH-1:0] req_b,
   output logic [WIDTH-1:0]         add_a,
   output logic [WIDTH-1:0]         add_b,
   output logic                     add_cin,
   input  logic [WIDTH-1:0]         add_sum,
   input  logic                     add_cout,
   input  logic                     add_neq,
   input  logic                     add_lt,
   output logic                     resp_valid,
   input  logic                     resp_ready,
   output logic [IDW-1:0]           resp_id,
   output logic [WIDTH-1:0]         resp_sum,
   output logic                     resp_cout,
   output logic                     resp_neq,
   output logic                     resp_lt
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t             r_state;
   state_t             w_nextState;
   logic [IDW-1:0]     r_rrPtr;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic               r_sub;
   logic [IDW-1:0]     r_id;
   logic               r_respValid;
   logic [IDW-1:0]     r_respId;
   logic [WIDTH-1:0]   r_respSum;
   logic               r_respCout;
   logic               r_respNeq;
   logic               r_respLt;
   logic               w_found;
   logic [IDW-1:0]     w_winId;
   logic [NUM_REQ-1:0] w_grant;
   logic [IDW-1:0]     w_nextPtr;

   // Rotating scan from the pointer; with fixed priority the pointer never leaves 0.
   always_comb begin
      int idx;
      idx     = 0;
      w_found = 1'b0;
      w_winId = '0;
      w_grant = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(r_rrPtr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!w_found && req_valid[idx]) begin
            w_found = 1'b1;
            w_winId = IDW'(idx);
         end
      end
      if (r_state == IDLE && w_found) w_grant[w_winId] = 1'b1;
   end

   assign req_ready = w_grant;
   assign w_nextPtr = (r_id == IDW'(NUM_REQ - 1)) ? '0 : r_id + 1'b1;

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_found) w_nextState = ISSUE;
         ISSUE:   w_nextState = RESP;
         RESP:    if (resp_ready) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_nextState;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rrPtr     <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_sub       <= 1'b0;
         r_id        <= '0;
         r_respValid <= 1'b0;
         r_respId    <= '0;
         r_respSum   <= '0;
         r_respCout  <= 1'b0;
         r_respNeq   <= 1'b0;
         r_respLt    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_found) begin
                  r_a   <= req_a[w_winId*WIDTH +: WIDTH];
                  r_b   <= req_b[w_winId*WIDTH +: WIDTH];
                  r_sub <= req_sub[w_winId];
                  r_id  <= w_winId;
               end
            end
            ISSUE: begin
               r_respValid <= 1'b1;
               r_respId    <= r_id;
               r_respSum   <= add_sum;
               r_respCout  <= add_cout;
               r_respNeq   <= add_neq;
               r_respLt    <= add_lt;
            end
            RESP: begin
               if (resp_ready) begin
                  r_respValid <= 1'b0;
`ifdef ARB_FIXED_PRIO_EN
                  r_rrPtr     <= '0;
`else
                  r_rrPtr     <= w_nextPtr;
`endif
               end
            end
            default: ;
         endcase
      end
   end

   // Operand regs only change on accept, so the adder inputs hold outside ISSUE.
   assign add_a   = r_a;
   assign add_b   = r_sub ? ~r_b : r_b;
   assign add_cin = r_sub;

   assign resp_valid = r_respValid;
   assign resp_id    = r_respId;
   assign resp_sum   = r_respSum;
   assign resp_cout  = r_respCout;
   assign resp_neq   = r_respNeq;
   assign resp_lt    = r_respLt;

endmodule

// File: tb/tb_cla_add_arbiter.sv
// Directed bench for cla_add_arbiter with a behavioural model of the external 32-bit adder.
// Honours ARB_FIXED_PRIO_EN for the arbitration-order checks.
module tb_cla_add_arbiter;

   localparam int N = 4;
   localparam int W = 32;

   logic           clk;
   logic           rst;
   logic [N-1:0]   reqValid;
   logic [N-1:0]   reqReady;
   logic [N-1:0]   reqSub;
   logic [N*W-1:0] reqA;
   logic [N*W-1:0] reqB;
   logic [W-1:0]   addA;
   logic [W-1:0]   addB;
   logic           addCin;
   logic [W-1:0]   addSum;
   logic           addCout;
   logic           addNeq;
   logic           addLt;
   logic           respValid;
   logic           respReady;
   logic [1:0]     respId;
   logic [W-1:0]   respSum;
   logic           respCout;
   logic           respNeq;
   logic           respLt;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int         id;
      logic       sub;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] sum;
      logic       cout;
      logic       neq;
      logic       lt;
   } vec_t;

   vec_t vecs[7];

   cla_add_arbiter #(.NUM_REQ(N), .WIDTH(W), .IDW(2)) dut (
      .clk(clk), .rst(rst),
      .req_valid(reqValid), .req_ready(reqReady), .req_sub(reqSub),
      .req_a(reqA), .req_b(reqB),
      .add_a(addA), .add_b(addB), .add_cin(addCin),
      .add_sum(addSum), .add_cout(addCout), .add_neq(addNeq), .add_lt(addLt),
      .resp_valid(respValid), .resp_ready(respReady), .resp_id(respId),
      .resp_sum(respSum), .resp_cout(respCout), .resp_neq(respNeq), .resp_lt(respLt)
   );

   // Stand-in for the cla_32bit instance: raw carry, nonzero flag, signed less-than from subtraction.
   logic [W:0] full;
   logic       ovf;
   assign full    = {1'b0, addA} + {1'b0, addB} + {{W{1'b0}}, addCin};
   assign addSum  = full[W-1:0];
   assign addCout = full[W];
   assign addNeq  = |full[W-1:0];
   assign ovf     = (addA[W-1] == addB[W-1]) && (full[W-1] != addA[W-1]);
   assign addLt   = full[W-1] ^ ovf;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // One full transaction on a single requester, checking grant, adder drive, latency and response.
   task automatic applyStimulus(input vec_t v);
      int n;
      logic [W-1:0] expB;
      expB = v.sub ? ~v.b : v.b;
      @(negedge clk);
      respReady = 1'b0;
      reqValid = '0;
      reqValid[v.id] = 1'b1;
      reqSub[v.id] = v.sub;
      reqA[v.id*W +: W] = v.a;
      reqB[v.id*W +: W] = v.b;
      #1;
      n = 0;
      while (!reqReady[v.id] && n < 10) begin
         @(negedge clk);
         #1;
         n++;
      end
      checkOutput("grant", 64'(reqReady), 64'(1) << v.id);
      @(posedge clk);
      #1;
      reqValid = '0;
      checkOutput("issue_resp_valid", 64'(respValid), 64'd0);
      checkOutput("add_a", 64'(addA), 64'(v.a));
      checkOutput("add_b", 64'(addB), 64'(expB));
      checkOutput("add_cin", 64'(addCin), 64'(v.sub));
      @(posedge clk);
      #1;
      checkOutput("resp_valid", 64'(respValid), 64'd1);
      checkOutput("resp_id", 64'(respId), 64'(v.id));
      checkOutput("resp_sum", 64'(respSum), 64'(v.sum));
      checkOutput("resp_cout", 64'(respCout), 64'(v.cout));
      checkOutput("resp_neq", 64'(respNeq), 64'(v.neq));
      if (v.sub) checkOutput("resp_lt", 64'(respLt), 64'(v.lt));
      respReady = 1'b1;
      @(posedge clk);
      #1;
      respReady = 1'b0;
      checkOutput("resp_drop", 64'(respValid), 64'd0);
   endtask

   initial begin
      int count;
      int lastCyc;
      int n;
      logic [N-1:0] expReady;

      rst = 1'b1;
      reqValid = '0;
      reqSub = '0;
      reqA = '0;
      reqB = '0;
      respReady = 1'b0;

      vecs[0] = '{0, 1'b0, 32'd14,         32'd1,          32'd15,         1'b0, 1'b1, 1'b0};
      vecs[1] = '{1, 1'b1, 32'd5,          32'd6,          32'hFFFFFFFF,   1'b0, 1'b1, 1'b1};
      vecs[2] = '{2, 1'b1, 32'd753,        32'd753,        32'd0,          1'b1, 1'b0, 1'b0};
      vecs[3] = '{3, 1'b0, 32'hFFFFFFFF,   32'd1,          32'd0,          1'b1, 1'b0, 1'b0};
      vecs[4] = '{1, 1'b1, 32'd10,         32'd3,          32'd7,          1'b1, 1'b1, 1'b0};
      vecs[5] = '{0, 1'b1, 32'h80000000,   32'd1,          32'h7FFFFFFF,   1'b1, 1'b1, 1'b1};
      vecs[6] = '{3, 1'b0, 32'h12345678,   32'h11111111,   32'h23456789,   1'b0, 1'b1, 1'b0};

      // Reset values with reset still asserted.
      repeat (2) @(negedge clk);
      checkOutput("rst_resp_valid", 64'(respValid), 64'd0);
      checkOutput("rst_resp_sum", 64'(respSum), 64'd0);
      checkOutput("rst_resp_id", 64'(respId), 64'd0);
      checkOutput("rst_add_a", 64'(addA), 64'd0);
      checkOutput("rst_add_b", 64'(addB), 64'd0);
      checkOutput("rst_add_cin", 64'(addCin), 64'd0);
      checkOutput("rst_req_ready", 64'(reqReady), 64'd0);
      rst = 1'b0;

      for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

      // All four requesters held valid for eight back-to-back ops.
      doReset();
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         reqSub[i] = 1'b0;
         reqA[i*W +: W] = 32'(i * 10);
         reqB[i*W +: W] = 32'd1;
      end
      reqValid = '1;
      respReady = 1'b1;
      count = 0;
      lastCyc = 0;
      for (int cyc = 0; cyc < 60 && count < 8; cyc++) begin
         @(posedge clk);
         #1;
         if (respValid) begin
`ifdef ARB_FIXED_PRIO_EN
            checkOutput("rr_id", 64'(respId), 64'd0);
            checkOutput("rr_sum", 64'(respSum), 64'd1);
`else
            checkOutput("rr_id", 64'(respId), 64'(count % N));
            checkOutput("rr_sum", 64'(respSum), 64'((count % N) * 10 + 1));
`endif
            if (count > 0) checkOutput("rr_spacing", 64'(cyc - lastCyc), 64'd3);
            lastCyc = cyc;
            count++;
         end
      end
      checkOutput("rr_count", 64'(count), 64'd8);
      @(negedge clk);
      reqValid = '0;
      repeat (2) @(negedge clk);
      respReady = 1'b0;

      // Backpressure: response held while the consumer stalls, no grants meanwhile.
      reqValid[2] = 1'b1;
      reqSub[2] = 1'b0;
      reqA[2*W +: W] = 32'd100;
      reqB[2*W +: W] = 32'd23;
      #1;
      n = 0;
      while (!reqReady[2] && n < 10) begin
         @(negedge clk);
         #1;
         n++;
      end
      checkOutput("bp_grant", 64'(reqReady), 64'b0100);
      @(posedge clk);
      #1;
      reqValid = '0;
      @(posedge clk);
      #1;
      checkOutput("bp_valid", 64'(respValid), 64'd1);
      @(negedge clk);
      reqValid = '1;
      repeat (5) begin
         @(posedge clk);
         #1;
         checkOutput("bp_hold_valid", 64'(respValid), 64'd1);
         checkOutput("bp_hold_sum", 64'(respSum), 64'd123);
         checkOutput("bp_hold_id", 64'(respId), 64'd2);
         checkOutput("bp_no_ready", 64'(reqReady), 64'd0);
      end
      @(negedge clk);
      respReady = 1'b1;
      @(posedge clk);
      #1;
      respReady = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
      expReady = 4'b0001;
`else
      expReady = 4'b1000;
`endif
      checkOutput("bp_release_valid", 64'(respValid), 64'd0);
      checkOutput("bp_release_ready", 64'(reqReady), 64'(expReady));
      @(negedge clk);
      reqValid = '0;

      // Reset in ISSUE drops the in-flight op without a response.
      @(negedge clk);
      reqValid[0] = 1'b1;
      reqSub[0] = 1'b0;
      reqA[0 +: W] = 32'hFFFFFFFF;
      reqB[0 +: W] = 32'd1;
      #1;
      checkOutput("rst6_grant", 64'(reqReady), 64'b0001);
      @(posedge clk);
      #1;
      reqValid = '0;
      checkOutput("rst6_issue_a", 64'(addA), 64'hFFFFFFFF);
      rst = 1'b1;
      #1;
      checkOutput("rst6_valid", 64'(respValid), 64'd0);
      checkOutput("rst6_sum", 64'(respSum), 64'd0);
      rst = 1'b0;
      repeat (4) begin
         @(posedge clk);
         #1;
         checkOutput("rst6_no_resp", 64'(respValid), 64'd0);
      end
      applyStimulus('{0, 1'b0, 32'd999, 32'd0, 32'd999, 1'b0, 1'b1, 1'b0});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
